// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes that select the
// multiply latency class, FSM states, flag bit positions and latency helper.
package alu_ctrl_pkg;

  localparam logic [6:0] OP_MULTU = 7'b0000001;
  localparam logic [6:0] OP_MULT  = 7'b0000010;

  // Bit positions inside rsp_flags = {sign, carry, overflow, zero}
  localparam int unsigned FLAG_ZERO  = 32'd0;
  localparam int unsigned FLAG_OVF   = 32'd1;
  localparam int unsigned FLAG_CARRY = 32'd2;
  localparam int unsigned FLAG_SIGN  = 32'd3;
  localparam int unsigned FLAG_W     = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // True for the two opcodes that use the long multiply latency and own HI/LO
  function automatic logic is_mul_op(input logic [6:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  // Number of cycles the ALU needs before its outputs may be captured
  function automatic int unsigned op_latency(input logic [6:0] op,
                                             input int unsigned mul_lat,
                                             input int unsigned alu_lat);
    return is_mul_op(op) ? mul_lat : alu_lat;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Down-counter that times how long the ALU inputs are held for one op.
// Clear beats load, load beats decrement; it saturates at zero.
module alu_lat_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, load, or decrement toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the shared ALU: accepts one op, holds the
// ALU inputs for the op's latency, captures the results and returns them.
// Architectural HI/LO live here and are written only by multiplies.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic             alu_zflag,
  input  logic             alu_overflowflag,
  input  logic             alu_carryflag,
  input  logic             alu_signflag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [3:0]       rsp_flags
);

  localparam int unsigned LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 32'd1);

  state_e state_q, state_d;

  logic             accept_s;
  logic             capture_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] load_val_s;

  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       flags_q, flags_d;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign load_val_s = CNT_W'(op_latency(7'(req_op), MUL_LAT, ALU_LAT) - 32'd1);

  alu_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush),
    .load_i     (accept_s),
    .load_val_i (load_val_s),
    .dec_i      (state_q == EXEC),
    .cnt_o      (cnt_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state logic; flush overrides every handshake
  always_comb begin
    state_d   = state_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready && !flush) begin
          accept_s = 1'b1;
          state_d  = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_zero_s) begin
          capture_s = 1'b1;
          state_d   = RESP;
        end else begin
          state_d = EXEC;
        end
      end
      RESP: begin
        if (flush || rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next values: operands load on accept, results load on capture
  always_comb begin
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
    mul_d    = mul_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    flags_d  = flags_q;
    if (accept_s) begin
      in1_d = req_a;
      in2_d = req_b;
      op_d  = req_op;
      mul_d = is_mul_op(7'(req_op));
    end else begin
      mul_d = mul_q;
    end
    if (capture_s) begin
      result_d            = alu_result;
      flags_d[FLAG_ZERO]  = alu_zflag;
      flags_d[FLAG_OVF]   = alu_overflowflag;
      flags_d[FLAG_CARRY] = alu_carryflag;
      flags_d[FLAG_SIGN]  = alu_signflag;
      if (mul_q) begin
        hi_d = alu_hi;
        lo_d = alu_lo;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else begin
      result_d = result_q;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      mul_q    <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      flags_q  <= 4'b0000;
    end else begin
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      flags_q  <= flags_d;
    end
  end

  assign alu_input1 = in1_q;
  assign alu_input2 = in2_q;
  assign alu_op     = op_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = result_q;
  assign rsp_hi     = hi_q;
  assign rsp_lo     = lo_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU behind it.
// Expected responses are queued when an op is issued and popped on rsp_valid.
module tb_alu_issue_ctrl;

  localparam int W   = 32;
  localparam int OPW = 7;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [OPW-1:0] req_op, alu_op;
  logic [W-1:0]  req_a, req_b, alu_input1, alu_input2;
  logic [W-1:0]  alu_result, alu_hi, alu_lo;
  logic          alu_zflag, alu_overflowflag, alu_carryflag, alu_signflag;
  logic [W-1:0]  rsp_result, rsp_hi, rsp_lo;
  logic [3:0]    rsp_flags;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [3:0]   flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .OP_W(OPW), .MUL_LAT(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .alu_zflag(alu_zflag), .alu_overflowflag(alu_overflowflag),
    .alu_carryflag(alu_carryflag), .alu_signflag(alu_signflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_flags(rsp_flags)
  );

  // Behavioural ALU: 0 add, 1 multu, 2 mult, others xor; non-multiplies
  // drive junk on hi/lo so stray HI/LO writes become visible
  logic [32:0] sum;
  logic [63:0] prod_u, prod_s;
  always_comb begin
    sum    = {1'b0, alu_input1} + {1'b0, alu_input2};
    prod_u = {32'd0, alu_input1} * {32'd0, alu_input2};
    prod_s = $signed({{32{alu_input1[31]}}, alu_input1}) *
             $signed({{32{alu_input2[31]}}, alu_input2});
    alu_carryflag    = 1'b0;
    alu_overflowflag = 1'b0;
    alu_hi           = alu_input1;
    alu_lo           = alu_input2;
    case (alu_op)
      7'd0: begin
        alu_result       = sum[31:0];
        alu_carryflag    = sum[32];
        alu_overflowflag = (alu_input1[31] == alu_input2[31]) && (sum[31] != alu_input1[31]);
      end
      7'd1: begin
        {alu_hi, alu_lo} = prod_u;
        alu_result       = prod_u[31:0];
      end
      7'd2: begin
        {alu_hi, alu_lo} = prod_s;
        alu_result       = prod_s[31:0];
      end
      default: alu_result = alu_input1 ^ alu_input2;
    endcase
    alu_zflag    = (alu_result == 32'd0);
    alu_signflag = alu_result[31];
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] res, hi, lo, input logic [3:0] flags);
    exp_t e;
    e.res = res; e.hi = hi; e.lo = lo; e.flags = flags;
    sb_q.push_back(e);
  endtask

  task automatic start_req(input logic [OPW-1:0] op, input logic [W-1:0] a, b);
    int guard = 0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_val("req_ready_wait", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    check_val("alu_op_load", 64'(alu_op), 64'(op));
    check_val("alu_in1_load", 64'(alu_input1), 64'(a));
    check_val("alu_in2_load", 64'(alu_input2), 64'(b));
  endtask

  task automatic run_exec(input int lat, input logic [OPW-1:0] op, input logic [W-1:0] a, b);
    check_val("rsp_valid_early", 64'(rsp_valid), 64'(0));
    for (int i = 1; i < lat; i++) begin
      tick();
      check_val("rsp_valid_exec", 64'(rsp_valid), 64'(0));
      check_val("req_ready_exec", 64'(req_ready), 64'(0));
      check_val("alu_op_held", 64'(alu_op), 64'(op));
      check_val("alu_in1_held", 64'(alu_input1), 64'(a));
      check_val("alu_in2_held", 64'(alu_input2), 64'(b));
    end
    tick();
    check_val("rsp_valid_lat", 64'(rsp_valid), 64'(1));
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 64'(0), 64'(1));
    end else begin
      last_exp = sb_q.pop_front();
      check_val("rsp_result", 64'(rsp_result), 64'(last_exp.res));
      check_val("rsp_hi", 64'(rsp_hi), 64'(last_exp.hi));
      check_val("rsp_lo", 64'(rsp_lo), 64'(last_exp.lo));
      check_val("rsp_flags", 64'(rsp_flags), 64'(last_exp.flags));
    end
  endtask

  task automatic finish_rsp(input int bp);
    for (int i = 0; i < bp; i++) begin
      tick();
      check_val("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check_val("bp_req_ready", 64'(req_ready), 64'(0));
      check_val("bp_rsp_result", 64'(rsp_result), 64'(last_exp.res));
      check_val("bp_rsp_flags", 64'(rsp_flags), 64'(last_exp.flags));
      check_val("bp_rsp_lo", 64'(rsp_lo), 64'(last_exp.lo));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    check_val("req_ready_idle", 64'(req_ready), 64'(1));
  endtask

  task automatic do_op(input logic [OPW-1:0] op, input logic [W-1:0] a, b, input int lat,
                       input logic [W-1:0] res, hi, lo, input logic [3:0] flags);
    push_exp(res, hi, lo, flags);
    start_req(op, a, b);
    run_exec(lat, op, a, b);
    finish_rsp(0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check_val({tag, "_rsp_result"}, 64'(rsp_result), 64'(0));
    check_val({tag, "_rsp_hi"}, 64'(rsp_hi), 64'(0));
    check_val({tag, "_rsp_lo"}, 64'(rsp_lo), 64'(0));
    check_val({tag, "_rsp_flags"}, 64'(rsp_flags), 64'(0));
    check_val({tag, "_alu_op"}, 64'(alu_op), 64'(0));
    check_val({tag, "_alu_in1"}, 64'(alu_input1), 64'(0));
    check_val({tag, "_alu_in2"}, 64'(alu_input2), 64'(0));
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    tick();
    check_val("req_ready_in_rst", 64'(req_ready), 64'(0));
    check_reset_vals("reset");
    tick();
    rst = 1'b0;
    #1;
    check_val("req_ready_after_rst", 64'(req_ready), 64'(1));

    // add, multu, mult, then add that must not touch HI/LO
    do_op(7'd0, 32'd5, 32'd7, 1, 32'd12, 32'd0, 32'd0, 4'b0000);
    do_op(7'd1, 32'h4000_0000, 32'h4000_0000, 4, 32'd0, 32'h1000_0000, 32'h0000_0000, 4'b0001);
    do_op(7'd2, 32'hBFFF_FFFF, 32'h4000_0000, 4, 32'hC000_0000, 32'hEFFF_FFFF, 32'hC000_0000, 4'b1000);
    do_op(7'd0, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 32'hEFFF_FFFF, 32'hC000_0000, 4'b0101);

    // backpressure with a second request held during RESP
    push_exp(32'h8000_0000, 32'hEFFF_FFFF, 32'hC000_0000, 4'b1010);
    start_req(7'd0, 32'h7FFF_FFFF, 32'd1);
    run_exec(1, 7'd0, 32'h7FFF_FFFF, 32'd1);
    req_op = 7'd0; req_a = 32'd3; req_b = 32'd4; req_valid = 1'b1;
    finish_rsp(3);
    check_val("bp_no_early_accept", 64'(alu_input1), 64'(32'h7FFF_FFFF));
    push_exp(32'd7, 32'hEFFF_FFFF, 32'hC000_0000, 4'b0000);
    start_req(7'd0, 32'd3, 32'd4);
    run_exec(1, 7'd0, 32'd3, 32'd4);
    finish_rsp(0);

    // flush together with a request in IDLE: nothing accepted
    req_op = 7'd1; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_val("idle_flush_no_accept", 64'(alu_input1), 64'(32'd3));
    check_val("idle_flush_ready", 64'(req_ready), 64'(1));

    // flush in the second EXEC cycle of a multu
    start_req(7'd1, 32'd3, 32'd5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_rsp_valid", 64'(rsp_valid), 64'(0));
    check_val("flush_req_ready", 64'(req_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("flush_no_rsp", 64'(rsp_valid), 64'(0));
      check_val("flush_hi", 64'(rsp_hi), 64'(32'hEFFF_FFFF));
      check_val("flush_lo", 64'(rsp_lo), 64'(32'hC000_0000));
    end

    // reset in the middle of EXEC
    start_req(7'd2, 32'hBFFF_FFFF, 32'h4000_0000);
    tick();
    rst = 1'b1;
    #1;
    check_val("exec_rst_ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals("exec_rst");
    check_val("exec_rst_req_ready", 64'(req_ready), 64'(1));

    // reset while a response is waiting
    push_exp(32'd4, 32'd0, 32'd0, 4'b0000);
    start_req(7'd0, 32'd2, 32'd2);
    run_exec(1, 7'd0, 32'd2, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_reset_vals("resp_rst");

    // normal operation resumes
    do_op(7'd0, 32'd9, 32'd1, 1, 32'd10, 32'd0, 32'd0, 4'b0000);
    check_val("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
